// File: rtl/qspi_ram_responder_pkg.sv
// qspi_ram_responder_pkg: shared state encoding, command codes and address geometry
// for the QSPI PSRAM responder.
package qspi_ram_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_QREAD   = 8'hEB;
    localparam logic [7:0] CMD_QWRITE  = 8'h38;
    localparam logic [7:0] CMD_QPI_ON  = 8'h35;
    localparam logic [7:0] CMD_QPI_OFF = 8'hF5;

    localparam int ADDR_BITS    = 24;
    localparam int ADDR_NIBBLES = ADDR_BITS / 4;
    localparam int CMD_BITS     = 8;

    function automatic logic is_busy_state(input state_t s);
        return s inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA};
    endfunction

    function automatic logic is_rw_cmd(input logic [7:0] c);
        return (c == CMD_QREAD) || (c == CMD_QWRITE);
    endfunction

endpackage

// File: rtl/qspi_ram_responder_sync.sv
// qspi_resp_sync: 2-flop synchronizer for the PMOD inputs with rise/fall pulses on the
// strobe bits (csn, clk); level bits (io, bank) share the same depth so all stay aligned.
module qspi_resp_sync #(
    parameter int                EDGE_W   = 2,
    parameter int                LEVEL_W  = 6,
    parameter logic [EDGE_W-1:0] EDGE_RST = '0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [EDGE_W-1:0]  i_edge_async,
    input  logic [LEVEL_W-1:0] i_level_async,
    output logic [EDGE_W-1:0]  o_rise,
    output logic [EDGE_W-1:0]  o_fall,
    output logic [LEVEL_W-1:0] o_level
);

    logic [EDGE_W-1:0]  r_edge_meta;
    logic [EDGE_W-1:0]  r_edge_sync;
    logic [EDGE_W-1:0]  r_edge_prev;
    logic [LEVEL_W-1:0] r_level_meta;
    logic [LEVEL_W-1:0] r_level_sync;

    // NOTE: non-blocking assignments make every stage take the pre-edge value, so the chain shifts one stage per clock.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_edge_meta  <= EDGE_RST;
            r_edge_sync  <= EDGE_RST;
            r_edge_prev  <= EDGE_RST;
            r_level_meta <= '0;
            r_level_sync <= '0;
        end else begin
            r_edge_meta  <= i_edge_async;
            r_edge_sync  <= r_edge_meta;
            r_edge_prev  <= r_edge_sync;
            r_level_meta <= i_level_async;
            r_level_sync <= r_level_meta;
        end
    end

    assign o_rise  = r_edge_sync & ~r_edge_prev;
    assign o_fall  = ~r_edge_sync & r_edge_prev;
    assign o_level = r_level_sync;

endmodule

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: QSPI PSRAM stand-in serving a local byte array (quad read 0xEB, quad write 0x38).
// Define QSPI_RESP_QPI_EN to add QPI command mode (0x35 enters, 0xF5 exits). DUMMY must be >= 1.
module qspi_ram_responder
    import qspi_ram_responder_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter int         DUMMY  = 6,
    parameter logic [1:0] BANK   = 2'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_ram_csn,
    input  logic       in_ram_clk,
    input  logic [1:0] in_ram_bank,
    input  logic [3:0] in_ram_io,
    output logic [3:0] out_ram_io,
    output logic [3:0] out_ram_io_oe,
    output logic       out_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [1:0] w_rise;
    logic [1:0] w_fall;
    logic [5:0] w_level;
    logic       w_csn_rise;
    logic       w_csn_fall;
    logic       w_clk_rise;
    logic       w_clk_fall;
    logic [1:0] w_bank;
    logic [3:0] w_io;

    qspi_resp_sync #(
        .EDGE_W  (2),
        .LEVEL_W (6),
        .EDGE_RST(2'b10)
    ) u_sync (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_edge_async ({in_ram_csn, in_ram_clk}),
        .i_level_async({in_ram_bank, in_ram_io}),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_level      (w_level)
    );

    assign w_csn_rise = w_rise[1];
    assign w_csn_fall = w_fall[1];
    assign w_clk_rise = w_rise[0];
    assign w_clk_fall = w_fall[0];
    assign w_bank     = w_level[5:4];
    assign w_io       = w_level[3:0];

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_cnt;
    logic [6:0]        r_cmd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_nib_hi;
    logic [3:0]        r_wr_hi;
    logic [7:0]        r_rdata;
    logic [3:0]        r_io_out;
    logic              r_oe;
    logic              r_busy;
    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        w_cmd_byte;
    logic              w_cmd_last;
    logic              w_mem_re;
    logic              w_mem_we;

`ifdef QSPI_RESP_QPI_EN
    logic r_qpi;
    logic r_mode_req_vld;
    logic r_mode_req_val;

    // In QPI mode a command is two nibbles; otherwise eight bits on io0.
    assign w_cmd_byte = r_qpi ? {r_cmd[3:0], w_io} : {r_cmd, w_io[0]};
    assign w_cmd_last = r_qpi ? (r_cnt == 8'd1) : (r_cnt == 8'(CMD_BITS - 1));

    // The requested mode change is held until csn rises so the current transaction is unaffected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_qpi          <= 1'b0;
            r_mode_req_vld <= 1'b0;
            r_mode_req_val <= 1'b0;
        end else if (w_csn_rise) begin
            if (r_mode_req_vld) begin
                r_qpi <= r_mode_req_val;
            end
            r_mode_req_vld <= 1'b0;
        end else if (r_state == ST_CMD && w_clk_rise && w_cmd_last) begin
            if (!r_qpi && w_cmd_byte == CMD_QPI_ON) begin
                r_mode_req_vld <= 1'b1;
                r_mode_req_val <= 1'b1;
            end else if (r_qpi && w_cmd_byte == CMD_QPI_OFF) begin
                r_mode_req_vld <= 1'b1;
                r_mode_req_val <= 1'b0;
            end
        end
    end
`else
    assign w_cmd_byte = {r_cmd, w_io[0]};
    assign w_cmd_last = (r_cnt == 8'(CMD_BITS - 1));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        if (w_csn_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_csn_fall) begin
                        w_state_next = (w_bank == BANK) ? ST_CMD : ST_IGNORE;
                    end
                end
                ST_CMD: begin
                    if (w_clk_rise && w_cmd_last) begin
                        w_state_next = is_rw_cmd(w_cmd_byte) ? ST_ADDR : ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (w_clk_rise && r_cnt == 8'(ADDR_NIBBLES - 1)) begin
                        w_state_next = r_wr ? ST_WDATA : ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    if (w_clk_rise && r_cnt == 8'(DUMMY - 1)) begin
                        w_state_next = ST_RDATA;
                        w_mem_re     = 1'b1;
                    end
                end
                ST_RDATA: w_mem_re = w_clk_rise && r_nib_hi;
                ST_WDATA: w_mem_we = w_clk_rise && !r_nib_hi;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_nib_hi <= 1'b1;
            r_wr_hi  <= '0;
            r_io_out <= '0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= is_busy_state(w_state_next);
            if (w_csn_rise) begin
                r_oe     <= 1'b0;
                r_io_out <= '0;
                r_nib_hi <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt    <= '0;
                        r_cmd    <= '0;
                        r_addr   <= '0;
                        r_nib_hi <= 1'b1;
                    end
                    ST_CMD: begin
                        if (w_clk_rise) begin
                            r_cmd <= w_cmd_byte[6:0];
                            r_wr  <= (w_cmd_byte == CMD_QWRITE);
                            r_cnt <= w_cmd_last ? 8'd0 : r_cnt + 8'd1;
                        end
                    end
                    ST_ADDR: begin
                        if (w_clk_rise) begin
                            r_addr <= {r_addr[ADDR_W-5:0], w_io};
                            r_cnt  <= (r_cnt == 8'(ADDR_NIBBLES - 1)) ? 8'd0 : r_cnt + 8'd1;
                        end
                    end
                    ST_DUMMY: begin
                        if (w_clk_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    ST_RDATA: begin
                        // High nibble goes out first; the address moves on once the low nibble is out.
                        if (w_clk_fall) begin
                            r_oe <= 1'b1;
                            if (r_nib_hi) begin
                                r_io_out <= r_rdata[7:4];
                                r_nib_hi <= 1'b0;
                            end else begin
                                r_io_out <= r_rdata[3:0];
                                r_addr   <= r_addr + ADDR_W'(1);
                                r_nib_hi <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_clk_rise) begin
                            if (r_nib_hi) begin
                                r_wr_hi  <= w_io;
                                r_nib_hi <= 1'b0;
                            end else begin
                                r_addr   <= r_addr + ADDR_W'(1);
                                r_nib_hi <= 1'b1;
                            end
                        end
                    end
                    default: r_oe <= 1'b0;
                endcase
            end
        end
    end

    // NOTE: the byte array and its read register have no reset so they map onto block RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= {r_wr_hi, w_io};
        end else if (w_mem_re) begin
            r_rdata <= r_mem[r_addr];
        end
    end

    assign out_ram_io    = r_io_out;
    assign out_ram_io_oe = {4{r_oe}};
    assign out_busy      = r_busy;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: drives the responder as a QSPI initiator; read nibbles are checked by a
// monitor against a queue filled from a plain byte-array model of the memory.
module tb_qspi_ram_responder;

    localparam int         ADDR_W = 10;
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam int         DUMMY  = 6;
    localparam logic [1:0] BANK   = 2'd0;
    localparam int         HALF   = 4;

    localparam logic [7:0] C_READ    = 8'hEB;
    localparam logic [7:0] C_WRITE   = 8'h38;
    localparam logic [7:0] C_QPI_ON  = 8'h35;
    localparam logic [7:0] C_QPI_OFF = 8'hF5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       csn   = 1'b1;
    logic       sclk  = 1'b0;
    logic [1:0] bank  = 2'd0;
    logic [3:0] io_in = 4'd0;
    logic [3:0] io_out;
    logic [3:0] io_oe;
    logic       busy;

    always #5 clock = ~clock;

    qspi_ram_responder #(
        .ADDR_W(ADDR_W),
        .DUMMY (DUMMY),
        .BANK  (BANK)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_ram_csn   (csn),
        .in_ram_clk   (sclk),
        .in_ram_bank  (bank),
        .in_ram_io    (io_in),
        .out_ram_io   (io_out),
        .out_ram_io_oe(io_oe),
        .out_busy     (busy)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [DEPTH];
    logic [3:0] exp_q [$];
    logic [7:0] wbuf [16];
    bit         model_qpi = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every initiator rise with oe asserted must match the next expected nibble.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge sclk);
            if (io_oe !== 4'h0) begin
                if (exp_q.size() == 0) begin
                    check("oe_outside_data", 32'(io_oe), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("oe_all_bits", 32'(io_oe), 32'hF);
                    check("rdata_nibble", 32'(io_out), 32'(e));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic sclk_pulse(input logic [3:0] v);
        io_in = v;
        wait_cyc(HALF);
        sclk = 1'b1;
        wait_cyc(HALF);
        sclk = 1'b0;
    endtask

    task automatic cs_begin(input logic [1:0] b);
        bank = b;
        csn  = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_end();
        csn   = 1'b1;
        io_in = 4'd0;
        wait_cyc(2 * HALF);
        check("busy_after_csn", 32'(busy), 32'h0);
        check("oe_after_csn", 32'(io_oe), 32'h0);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        if (model_qpi) begin
            sclk_pulse(c[7:4]);
            sclk_pulse(c[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) sclk_pulse({3'b000, c[i]});
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sclk_pulse(a[4*i +: 4]);
    endtask

    task automatic do_write(input logic [1:0] b, input int addr, input int n);
        cs_begin(b);
        send_cmd(C_WRITE);
        send_addr(24'(addr));
        check("busy_in_write", 32'(busy), 32'(b == BANK));
        for (int i = 0; i < n; i++) begin
            sclk_pulse(wbuf[i][7:4]);
            sclk_pulse(wbuf[i][3:0]);
            if (b == BANK) model_mem[(addr + i) % DEPTH] = wbuf[i];
        end
        cs_end();
    endtask

    task automatic push_expected(input int addr, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_mem[(addr + i) % DEPTH][7:4]);
            exp_q.push_back(model_mem[(addr + i) % DEPTH][3:0]);
        end
    endtask

    task automatic do_read(input int addr, input int n);
        cs_begin(BANK);
        send_cmd(C_READ);
        send_addr(24'(addr));
        check("busy_in_read", 32'(busy), 32'h1);
        push_expected(addr, n);
        repeat (DUMMY) sclk_pulse(4'h0);
        repeat (2 * n) sclk_pulse(4'h0);
        cs_end();
        check("read_all_consumed", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic do_ignored_cmd(input logic [7:0] c);
        cs_begin(BANK);
        send_cmd(c);
        wait_cyc(HALF);
        check("busy_after_unknown", 32'(busy), 32'h0);
        repeat (8) sclk_pulse(4'($urandom_range(0, 15)));
        check("busy_ignore_tail", 32'(busy), 32'h0);
        cs_end();
    endtask

    initial begin
        int off;
        int len;
        wait_cyc(5);
        check("reset_io", 32'(io_out), 32'h0);
        check("reset_oe", 32'(io_oe), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        wait_cyc(4);

        // Basic write then read-back.
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(BANK, 24'h10, 2);
        do_read(24'h10, 2);

        // Write across the top of the array wraps to address 0.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(BANK, DEPTH - 1, 2);
        do_read(0, 1);
        do_read(DEPTH - 1, 2);

        // Foreign bank must not touch the array.
        wbuf[0] = 8'h5A;
        do_write(BANK, 24'h20, 1);
        wbuf[0] = 8'hFF;
        do_write(2'd1, 24'h20, 1);
        do_read(24'h20, 1);

        // Unknown command is ignored.
        do_ignored_cmd(8'h9F);
        do_read(24'h10, 1);

        // Half byte at csn rise is discarded.
        wbuf[0] = 8'h77;
        do_write(BANK, 24'h40, 1);
        cs_begin(BANK);
        send_cmd(C_WRITE);
        send_addr(24'h40);
        sclk_pulse(4'hE);
        cs_end();
        do_read(24'h40, 1);

        // Reset in the middle of read data.
        cs_begin(BANK);
        send_cmd(C_READ);
        send_addr(24'h10);
        push_expected(24'h10, 1);
        repeat (DUMMY) sclk_pulse(4'h0);
        repeat (2) sclk_pulse(4'h0);
        wait_cyc(HALF);
        check("oe_before_reset", 32'(io_oe), 32'hF);
        reset = 1'b1;
        #1;
        check("oe_in_reset", 32'(io_oe), 32'h0);
        check("busy_in_reset", 32'(busy), 32'h0);
        csn = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(4);
        check("reset_read_consumed", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        do_read(24'h10, 2);

`ifdef QSPI_RESP_QPI_EN
        // Enter QPI, read and write with nibble-wide commands, then leave.
        do_ignored_cmd(C_QPI_ON);
        model_qpi = 1'b1;
        do_read(24'h10, 2);
        wbuf[0] = 8'hC3;
        do_write(BANK, 24'h50, 1);
        do_read(24'h50, 1);
        do_ignored_cmd(C_QPI_OFF);
        model_qpi = 1'b0;
        do_read(24'h50, 1);
`else
        // Without QPI support 0x35 is just another unknown command.
        do_ignored_cmd(C_QPI_ON);
        do_read(24'h10, 2);
`endif

        // Randomized traffic over a region straddling the wrap point.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_write(BANK, (1000 + 16 * k) % DEPTH, 16);
        end
        for (int k = 0; k < 24; k++) begin
            off = $urandom_range(0, 39);
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
                do_write(($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : BANK,
                         (1000 + off) % DEPTH, len);
            end else begin
                do_read((1000 + off) % DEPTH, len);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
